// File: rtl/cmd_spi_receiver.sv
// rtl/cmd_spi_receiver.sv - SPI mode-0 command receiver with latch-pulse output stage
// Defining CMD_PARITY_EN adds a 33rd odd-parity bit to every frame and to readback.
`timescale 1ns/1ps
module cmd_spi_receiver #(
    parameter int LATCH_HOLD  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] cmd_data,
    output logic        latch_data,
    output logic        frame_error,
    output logic [7:0]  err_count
);

`ifdef CMD_PARITY_EN
    localparam int FRAME_BITS = 33;
`else
    localparam int FRAME_BITS = 32;
`endif

    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_SHIFT = 1'b1;

    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_HOLD = 2'd1;
    localparam logic [1:0] OUT_GAP  = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_hist;
    logic                   csn_hist;

    logic sck_s;
    logic csn_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic csn_fall;
    logic csn_rise;

    logic [0:0]            rx_state;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] tx_load;
    logic [31:0]           rx_word;
    logic                  frame_ok;
    logic                  frame_end;
    logic                  word_valid;
    logic                  frame_reject;

    logic [1:0]  out_state;
    logic [3:0]  hold_cnt;
    logic        pend_valid;
    logic [31:0] pend_data;
    logic        out_idle;
    logic        pend_take;
    logic        pend_store;
    logic        overrun;
    logic        err_evt;

    // csn history resets high so a released bus never looks like a frame start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_hist  <= 1'b0;
            csn_hist  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            csn_hist  <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign csn_fall = ~csn_s & csn_hist;
    assign csn_rise = csn_s & ~csn_hist;

`ifdef CMD_PARITY_EN
    assign rx_word  = rx_shift[32:1];
    assign frame_ok = (bit_cnt == 6'(FRAME_BITS)) && (^rx_shift);
    assign tx_load  = {cmd_data, ~^cmd_data};
`else
    assign rx_word  = rx_shift;
    assign frame_ok = (bit_cnt == 6'(FRAME_BITS));
    assign tx_load  = cmd_data;
`endif

    assign frame_end    = (rx_state == RX_SHIFT) && csn_rise;
    assign word_valid   = frame_end && frame_ok;
    assign frame_reject = frame_end && !frame_ok;
    assign spi_miso     = tx_shift[FRAME_BITS-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (csn_fall) begin
                        rx_state <= RX_SHIFT;
                        bit_cnt  <= '0;
                        tx_shift <= tx_load;
                    end
                end
                default: begin
                    if (csn_rise) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                            if (bit_cnt != 6'd63) begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                        if (sck_fall) begin
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    // A finished word bypasses pending when the output stage is idle and empty.
    assign out_idle   = (out_state == OUT_IDLE);
    assign pend_take  = out_idle && pend_valid;
    assign overrun    = word_valid && pend_valid && !out_idle;
    assign pend_store = word_valid && !overrun && !(out_idle && !pend_valid);
    assign err_evt    = frame_reject || overrun;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_state  <= OUT_IDLE;
            hold_cnt   <= '0;
            latch_data <= 1'b0;
            cmd_data   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (pend_valid || word_valid) begin
                        cmd_data   <= pend_valid ? pend_data : rx_word;
                        latch_data <= 1'b1;
                        hold_cnt   <= 4'(LATCH_HOLD);
                        out_state  <= OUT_HOLD;
                    end
                end
                OUT_HOLD: begin
                    // Dropping on the last count keeps the high time at exactly LATCH_HOLD.
                    if (hold_cnt == 4'd1) begin
                        hold_cnt   <= '0;
                        latch_data <= 1'b0;
                        out_state  <= OUT_GAP;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    out_state <= OUT_IDLE;
                end
            endcase

            if (pend_store) begin
                pend_valid <= 1'b1;
                pend_data  <= rx_word;
            end else if (pend_take) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_error <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_error <= err_evt;
            if (err_evt && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
